aes_dec: RTL and testbench

AES_DEC -- requirements
Module: aes_dec

---
 rtl/aes_dec.sv | 130 +++++++++++++
 tb/tb_aes_dec.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec.sv
// aes_dec: fully unrolled, pipelined AES-128 inverse cipher.
// Round keys are expanded iteratively, one per cycle, into a register file.
module aes_dec (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] IN,
    input  logic [127:0] KEY,
    input  logic         enable,
    input  logic         fsm_en,
    output logic [127:0] OUT,
    output logic         valid_out
);
    localparam logic [0:255][7:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [0:255][7:0] ISBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d};
    localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 40'h0};

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state, nxt;
    logic         restart;
    logic [3:0]   rnd;
    logic [127:0] rk [0:10];
    logic [127:0] rk_next;
    logic [127:0] in_q;
    logic         v_in;
    logic [127:0] st [0:9];
    logic [0:9]   v;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] p, input logic [7:0] rc);
        logic [31:0]  t;
        logic [127:0] n;
        t = {SBOX[p[23:16]] ^ rc, SBOX[p[15:8]], SBOX[p[7:0]], SBOX[p[31:24]]};
        n[127:96] = p[127:96] ^ t;
        n[95:64]  = p[95:64] ^ n[127:96];
        n[63:32]  = p[63:32] ^ n[95:64];
        n[31:0]   = p[31:0] ^ n[63:32];
        return n;
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, optionally followed by InvMixColumns
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic mix);
        logic [127:0] t;
        logic [7:0]   a, x2, x4, x8;
        logic [7:0]   e [4], b [4], d [4], n [4];
        for (int i = 0; i < 16; i++)
            t[127-8*i -: 8] = ISBOX[s[127-8*((i%4) + 4*(((i/4) - (i%4)) & 3)) -: 8]];
        t = t ^ k;
        if (mix)
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    a = t[127-32*c-8*j -: 8];
                    x2 = xt(a);
                    x4 = xt(x2);
                    x8 = xt(x4);
                    e[j] = x8 ^ x4 ^ x2;
                    b[j] = x8 ^ x2 ^ a;
                    d[j] = x8 ^ x4 ^ a;
                    n[j] = x8 ^ a;
                end
                for (int j = 0; j < 4; j++)
                    t[127-32*c-8*j -: 8] = e[j] ^ b[(j+1)%4] ^ d[(j+2)%4] ^ n[(j+3)%4];
            end
        return t;
    endfunction

    assign rk_next = next_key(rk[rnd - 4'd1], RCON[rnd]);

    always_comb begin
        nxt = state;
        restart = 1'b0;
        if (fsm_en && state != EXPAND) begin
            nxt = EXPAND;
            restart = 1'b1;
        end else if (state == EXPAND && rnd == 4'd10) begin
            nxt = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rnd <= 4'd0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
            for (int i = 0; i < 10; i++) st[i] <= '0;
            in_q <= '0;
            v_in <= 1'b0;
            v <= '0;
            OUT <= '0;
            valid_out <= 1'b0;
        end else begin
            state <= nxt;
            if (restart) begin
                rk[0] <= KEY;
                rnd <= 4'd1;
            end else if (state == EXPAND) begin
                rk[rnd] <= rk_next;
                if (rnd != 4'd10) rnd <= rnd + 4'd1;
            end
            // a restart flushes every in-flight block, including one offered on the same edge
            in_q <= IN;
            v_in <= enable && state == READY && !restart;
            st[0] <= in_q ^ rk[10];
            for (int s = 1; s < 10; s++) st[s] <= inv_round(st[s-1], rk[10-s], 1'b1);
            OUT <= inv_round(st[9], rk[0], 1'b0);
            v <= restart ? '0 : {v_in, v[0:8]};
            valid_out <= v[9] && !restart;
        end
    end
endmodule

// File: tb/tb_aes_dec.sv
// tb_aes_dec: directed-vector bench for aes_dec.
// Vectors come from FIPS-197 constants and a bench-side AES-128 encryptor built from GF(2^8) arithmetic.
module tb_aes_dec;
    typedef struct packed {
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst, enable, fsm_en, valid_out;
    logic [127:0] IN, KEY, OUT;
    int           tests = 0, fails = 0, cyc = 0;
    logic [7:0]   sb [256];
    logic [127:0] mrk [11];
    logic [127:0] got_d [$];
    int           got_c [$];
    vec_t         v1 [11];
    vec_t         v2 [3];

    aes_dec dut (.clk(clk), .rst(rst), .IN(IN), .KEY(KEY), .enable(enable),
                 .fsm_en(fsm_en), .OUT(OUT), .valid_out(valid_out));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one clock edge; outputs are sampled 1ns later and every valid block is logged with its cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out) begin
            got_d.push_back(OUT);
            got_c.push_back(cyc);
        end
    endtask

    task automatic flush_log();
        got_d.delete();
        got_c.delete();
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] enc(input logic [127:0] p);
        logic [7:0]   a [16], b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = p[127-8*i -: 8] ^ mrk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sb[a[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    a[4*c+j] = (r == 10) ? b[4*c+j] :
                        gm(b[4*c+j], 8'h02) ^ gm(b[4*c+(j+1)%4], 8'h03) ^ b[4*c+(j+2)%4] ^ b[4*c+(j+3)%4];
            for (int i = 0; i < 16; i++) a[i] = a[i] ^ mrk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
        return o;
    endfunction

    initial begin
        int           a, b, c;
        logic [7:0]   inv, s;
        logic [127:0] p;
        rst = 1'b1; enable = 1'b0; fsm_en = 1'b0; IN = '0; KEY = '0;
        // forward S-box from multiplicative inverse plus affine map
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
        expand(K1);
        v1[0] = {128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        v1[1] = {128'hc6a13b37878f5b826f4f8162a1c8d879, 128'h0};
        for (int k = 2; k < 11; k++) begin
            p = (k == 2) ? '1 : {$urandom, $urandom, $urandom, $urandom};
            v1[k] = {enc(p), p};
        end
        expand(K2);
        v2[0] = {128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
        for (int k = 1; k < 3; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            v2[k] = {enc(p), p};
        end

        step();
        step();
        chki("reset valid_out", int'(valid_out), 0);
        chk("reset OUT", OUT, '0);
        rst = 1'b0;
        step();

        // key load; enables offered during expansion must be dropped
        flush_log();
        KEY = K1; fsm_en = 1'b1;
        step();
        fsm_en = 1'b0; KEY = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        IN = v1[0].ct; enable = 1'b1;
        repeat (10) step();
        step();
        a = cyc;
        enable = 1'b0; IN = '1;
        repeat (20) step();
        chki("single block count", got_d.size(), 1);
        if (got_d.size() > 0) begin
            chki("single block latency", got_c[0], a + 11);
            chk("single block data", got_d[0], v1[0].pt);
        end

        // 11 back-to-back blocks
        flush_log();
        enable = 1'b1;
        for (int k = 0; k < 11; k++) begin
            IN = v1[k].ct;
            step();
            if (k == 0) b = cyc;
        end
        enable = 1'b0;
        repeat (15) step();
        chki("stream count", got_d.size(), 11);
        for (int k = 0; k < 11; k++)
            if (k < got_d.size()) begin
                chk($sformatf("stream data %0d", k), got_d[k], v1[k].pt);
                chki($sformatf("stream cycle %0d", k), got_c[k], b + 11 + k);
            end

        // reset with blocks in flight; fsm_en/enable during reset are ignored
        flush_log();
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            IN = v1[k].ct;
            step();
        end
        enable = 1'b0;
        repeat (3) step();
        rst = 1'b1; fsm_en = 1'b1; enable = 1'b1; KEY = K1;
        step();
        chki("mid-stream reset valid_out", int'(valid_out), 0);
        chk("mid-stream reset OUT", OUT, '0);
        rst = 1'b0; fsm_en = 1'b0; IN = v1[0].ct;
        repeat (25) step();
        enable = 1'b0;
        repeat (12) step();
        chki("no output after reset", got_d.size(), 0);

        // reload K1, then rekey to K2 from READY with blocks in flight
        KEY = K1; fsm_en = 1'b1;
        step();
        fsm_en = 1'b0;
        repeat (10) step();
        flush_log();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            IN = v1[k].ct;
            step();
        end
        enable = 1'b0; KEY = K2; fsm_en = 1'b1;
        step();
        fsm_en = 1'b0;
        repeat (4) step();
        KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100; fsm_en = 1'b1;
        step();
        fsm_en = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            IN = v2[k].ct;
            step();
            if (k == 0) c = cyc;
        end
        enable = 1'b0;
        repeat (15) step();
        chki("rekey count", got_d.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < got_d.size()) begin
                chk($sformatf("rekey data %0d", k), got_d[k], v2[k].pt);
                chki($sformatf("rekey cycle %0d", k), got_c[k], c + 11 + k);
            end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
